// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the execute-stage divide unit: FSM state encoding,
// iteration count and default operand width.
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned DIV_W    = 32;

endpackage

// File: rtl/ex_div_unit_step.sv
// div_step: one combinational radix-2 restoring iteration. Shifts the
// dividend MSB into the partial remainder and subtracts the divisor if it fits.
module div_step #(
  parameter int unsigned DIV_W = ex_div_unit_pkg::DIV_W
) (
  input  logic [DIV_W-1:0] rem,
  input  logic             dvd_msb,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_nxt,
  output logic             q_bit
);

  logic [DIV_W:0]   shifted;
  logic [DIV_W+1:0] trial;

  always_comb begin
    shifted = {rem, dvd_msb};
    // One spare bit beyond the 33-bit trial so the sign is unambiguous.
    trial   = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = ~trial[DIV_W+1];
    rem_nxt = q_bit ? trial[DIV_W-1:0] : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle restoring integer divider for div.w/mod.w/div.wu/mod.wu with
// valid/ready on both sides and flush abort. Optional macro: DIV_ZERO_FAST_EN.
module ex_div_unit #(
  parameter int unsigned DIV_W = ex_div_unit_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic             req_quot,
  input  logic [DIV_W-1:0] req_src1,
  input  logic [DIV_W-1:0] req_src2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DIV_W-1:0] rsp_result,
  output logic             busy
);

  import ex_div_unit_pkg::*;

  div_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] dvd_q, dvd_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic [DIV_W-1:0] result_q, result_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             quot_q, quot_d;

  logic [DIV_W-1:0] step_rem;
  logic             step_q;
  logic             s1, s2;
  logic [DIV_W-1:0] quot_fix, rem_fix;

  div_step #(.DIV_W(DIV_W)) u_step (
    .rem     (step_rem_in()),
    .dvd_msb (dvd_q[DIV_W-1]),
    .divisor (dvs_q),
    .rem_nxt (step_rem),
    .q_bit   (step_q)
  );

  function automatic logic [DIV_W-1:0] step_rem_in();
    return rem_q;
  endfunction

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_result = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    quot_d   = quot_q;

    s1       = req_signed & req_src1[DIV_W-1];
    s2       = req_signed & req_src2[DIV_W-1];
    quot_fix = q_neg_q ? -dvd_q : dvd_q;
    rem_fix  = r_neg_q ? -rem_q : rem_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = s1 ? -req_src1 : req_src1;
          dvs_d   = s2 ? -req_src2 : req_src2;
          q_neg_d = s1 ^ s2;
          r_neg_d = s1;
          quot_d  = req_quot;
`ifdef DIV_ZERO_FAST_EN
          // Zero divisor: preload the algorithm's unsigned outcome and skip RUN.
          if (req_src2 == '0) begin
            state_d = FIX;
            dvd_d   = '1;
            rem_d   = req_src1;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        rem_d = step_rem;
        dvd_d = {dvd_q[DIV_W-2:0], step_q};
        if (cnt_q == 6'(DIV_ITER - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = quot_q ? quot_fix : rem_fix;
        state_d  = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      quot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      quot_q   <= quot_d;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed vector table, flush and
// backpressure sequences, and randomized ops against an arithmetic model.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, req_signed, req_quot;
  logic [31:0] req_src1, req_src2, rsp_result;
  logic        rsp_valid, rsp_ready, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_div_unit #(.DIV_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_quot   (req_quot),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  typedef struct {
    string       name;
    bit          sgn;
    bit          quot;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic plus the documented special cases.
  function automatic logic [31:0] ref_div(input bit sgn, input bit quot,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 32'd0) begin
      r = a;
`ifdef DIV_ZERO_FAST_EN
      q = 32'hFFFF_FFFF;
`else
      q = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
    return quot ? q : r;
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 2;
`endif
    return 34;
  endfunction

  // Called at posedge+1 while idle; returns at posedge+1 of the cycle after the handshake.
  task automatic run_op(input bit sgn, input bit quot, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat);
    req_valid  = 1'b1;
    req_signed = sgn;
    req_quot   = quot;
    req_src1   = a;
    req_src2   = b;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_src1   = $urandom;
    req_src2   = $urandom;
    req_signed = 1'($urandom);
    req_quot   = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_result;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  vec_t        vecs[$];
  logic [31:0] res, r0, a, b;
  int          lat, cyc;
  bit          sgn, quot;

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_quot = 1'b0;
    req_src1 = '0; req_src2 = '0; rsp_ready = 1'b0;

    vecs.push_back('{"u100div7",   1'b0, 1'b1, 32'd100,        32'd7,          32'h0000_000E});
    vecs.push_back('{"u100mod7",   1'b0, 1'b0, 32'd100,        32'd7,          32'h0000_0002});
    vecs.push_back('{"s-7div2",    1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{"s-7mod2",    1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{"ovf_div",    1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
    vecs.push_back('{"ovf_mod",    1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000});
`ifdef DIV_ZERO_FAST_EN
    vecs.push_back('{"s_div0_q",   1'b1, 1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF});
`else
    vecs.push_back('{"s_div0_q",   1'b1, 1'b1, 32'hFFFF_FFF0,  32'd0,          32'h0000_0001});
`endif
    vecs.push_back('{"s_div0_r",   1'b1, 1'b0, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0});
    vecs.push_back('{"u_div0_q",   1'b0, 1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{"u_div0_r",   1'b0, 1'b0, 32'h1234_5678,  32'd0,          32'h1234_5678});
    vecs.push_back('{"u_big",      1'b0, 1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0001});
    vecs.push_back('{"s7mod-2",    1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].quot, vecs[i].a, vecs[i].b, res, lat);
      chk(vecs[i].name, res, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_lat(vecs[i].b)));
      chk({vecs[i].name, "_idle"}, {30'd0, busy, req_ready}, 32'd1);
    end

    // Flush in RUN cycle 10.
    req_valid = 1'b1; req_signed = 1'b0; req_quot = 1'b1; req_src1 = 32'd50; req_src2 = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    run_op(1'b0, 1'b1, 32'd9, 32'd3, res, lat);
    chk("after_flush_9div3", res, 32'd3);
    chk("after_flush_lat", 32'(lat), 32'd34);

    // Flush beats accept.
    req_valid = 1'b1; flush = 1'b1; req_src1 = 32'd8; req_src2 = 32'd2;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept_busy", {31'd0, busy}, 32'd0);
    chk("flush_vs_accept_ready", {31'd0, req_ready}, 32'd1);

    // Backpressure: rsp_ready low for 5 cycles in DONE.
    req_valid = 1'b1; req_signed = 1'b0; req_quot = 1'b1; req_src1 = 32'd1000; req_src2 = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_lat", 32'(cyc), 32'd34);
    r0 = rsp_result;
    chk("bp_result", r0, 32'd333);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_stable", rsp_result, r0);
      chk("bp_valid_req_ready", {30'd0, rsp_valid, req_ready}, 32'd2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    chk("bp_idle", {29'd0, busy, req_ready, rsp_valid}, 32'd2);

    // Flush during DONE with rsp_ready: response dropped, back to IDLE.
    req_valid = 1'b1; req_src1 = 32'd77; req_src2 = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("done_before_flush", {31'd0, rsp_valid}, 32'd1);
    flush = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; rsp_ready = 1'b0;
    chk("done_flush_idle", {29'd0, busy, req_ready, rsp_valid}, 32'd2);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      sgn  = 1'($urandom);
      quot = 1'($urandom);
      a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      run_op(sgn, quot, a, b, res, lat);
      chk("rand_result", res, ref_div(sgn, quot, a, b));
      chk("rand_lat", 32'(lat), 32'(exp_lat(b)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Multi-cycle integer divide controller in the execute stage. It sequences a radix-2 restoring divider for div.w, mod.w, div.wu and mod.wu, with a valid/ready handshake on both sides. It exposes `busy` so execute can hold the instruction and raise its forward-block indication. On exception flush (ertn/syscall) it aborts cleanly.

## Interface
Parameters:
- `DIV_W`, default 32: operand and result width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `flush`, in, 1: pipeline flush; aborts any operation in progress.
- `req_valid`, in, 1: execute presents a divide.
- `req_ready`, out, 1: unit accepts the request; high only in IDLE.
- `req_signed`, in, 1: 1 = signed (div.w/mod.w), 0 = unsigned.
- `req_quot`, in, 1: 1 = return quotient, 0 = return remainder. Same polarity as the decode bus `div_mod` bit.
- `req_src1`, in, DIV_W: dividend (rj value).
- `req_src2`, in, DIV_W: divisor (rk value).
- `rsp_valid`, out, 1: result available.
- `rsp_ready`, in, 1: execute consumes the result.
- `rsp_result`, out, DIV_W: quotient or remainder.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE → RUN on accept (`req_valid && req_ready`).
  - RUN → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → IDLE on `rsp_valid && rsp_ready`.
- Accept latches:
  - |src1| and |src2| when signed, raw values when unsigned;
  - q_neg = s1^s2 and r_neg = s1, where s1 and s2 are the operand sign bits, forced 0 when unsigned;
  - req_quot.
- RUN: 6-bit counter runs 0..31. Each cycle performs one restoring step:
  - shift {rem, dividend} left by 1;
  - trial = rem − divisor, 33-bit;
  - if trial is non-negative, rem = trial and the new quotient bit is 1;
  - otherwise rem is kept and the new quotient bit is 0.
- FIX: negate the quotient if q_neg and the remainder if r_neg, using two's complement modulo 2^32. Select the output by req_quot and register it into `rsp_result`.
- DONE: `rsp_valid` = 1. `rsp_result` stays stable until the handshake.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no trap.
- Divide by zero without the macro follows the algorithm:
  - unsigned: quotient 0xFFFFFFFF, remainder src1;
  - signed: quotient = (src1 < 0) ? 0x00000001 : 0xFFFFFFFF, remainder src1.
- Flush:
  - In any state, next state is IDLE; no response is produced and any pending result is discarded.
  - Flush beats accept in the same cycle: the request is dropped.
  - Flush during DONE together with `rsp_ready` still counts as dropped; execute is being flushed.
- Reset: same effect as flush; all datapath registers clear to 0.

## Timing
- Reset values: `req_ready` = 1, `rsp_valid` = 0, `rsp_result` = 0, `busy` = 0.
- Latency: accept on edge E0. RUN occupies cycles 1–32 and FIX cycle 33. `rsp_valid` is first high in cycle 34.
- `busy` rises in the cycle after accept and falls in the cycle after the response handshake or flush.
- No overlap: the next accept is possible at the earliest in the cycle after the response handshake.
- `req_*` inputs are sampled only on the accept edge and may change freely afterwards.

## Configuration
- `DIV_ZERO_FAST_EN`, when defined:
  - a zero divisor detected at accept goes IDLE → FIX → DONE, skipping RUN;
  - `rsp_valid` rises in cycle 2;
  - result is quotient 0xFFFFFFFF and remainder src1 for both signed and unsigned.
- When undefined: all divides take 34 cycles, with the algorithmic results above.

## Structure
- Shared package holds:
  - state encoding IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3;
  - `DIV_ITER` = 32;
  - `DIV_W`.
- Sub-module `div_step`: combinational single restoring iteration. Inputs are rem, dividend MSB and divisor; outputs are the new rem and the quotient bit.
- Counter, FSM, sign handling and handshake live in `ex_div_unit`.

## Test plan
- Unsigned 100/7:
  - req_quot=1 → 0x0000000E with `rsp_valid` in cycle 34;
  - req_quot=0 → 0x00000002.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002):
  - quotient → 0xFFFFFFFD;
  - remainder → 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF: quotient → 0x80000000, remainder → 0.
- Divide 0xFFFFFFF0 by 0, signed, quotient:
  - without macro → 0x00000001 in cycle 34;
  - with `DIV_ZERO_FAST_EN` → 0xFFFFFFFF in cycle 2.
- Flush in RUN cycle 10:
  - next cycle `busy` = 0 and `req_ready` = 1, with no `rsp_valid`;
  - an immediate new request 9/3 returns 3.
- `rsp_ready` held low 5 cycles in DONE: `rsp_result` stays stable, `req_ready` = 0, and IDLE is entered the cycle after `rsp_ready` rises.
